// File: rtl/mdu_pkg.sv
// ============================================================================
//  Module      : mdu_pkg
//  Description : Shared encodings for the multiply/divide unit: operation
//                codes (also used by the datapath opcode/funct decode) and
//                the sequencer state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mdu_pkg;

    // Operation codes carried on the op bus; 6 and 7 are reserved.
    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_e;

    // Sequencer states.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PREP    = 3'd1,
        S_MUL_RUN = 3'd2,
        S_DIV_RUN = 3'd3,
        S_FINISH  = 3'd4
    } mdu_state_e;

    // True for the four iterative operations (MULT, MULTU, DIV, DIVU).
    function automatic logic mdu_is_muldiv(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_hilo_if.sv
// ============================================================================
//  Module      : mdu_hilo_if
//  Description : Core-side bus of the multiply/divide unit. The core is the
//                master (issues operations, reads HI/LO); the MDU is the
//                slave.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mdu_hilo_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] rs;
    logic [WIDTH-1:0] rt;
    logic             cancel;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs, rt, cancel,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, rs, rt, cancel,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

`default_nettype wire

// File: rtl/mdu_div_step.sv
// ============================================================================
//  Module      : mdu_div_step
//  Description : One combinational restoring-division step. Shifts the next
//                dividend bit into the partial remainder, trial-subtracts the
//                divisor and restores when the subtraction would go negative.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_div_step #(
    parameter int WIDTH = 32
) (
    input  wire logic [WIDTH-1:0] i_rem,
    input  wire logic             i_bit,
    input  wire logic [WIDTH-1:0] i_divisor,
    output logic      [WIDTH-1:0] o_rem,
    output logic                  o_q_bit
);

    logic [WIDTH:0] w_partial;
    logic [WIDTH:0] w_diff;

    // Trial subtraction; the partial remainder is one bit wider than the
    // divisor so the compare never overflows.
    always_comb begin
        w_partial = {i_rem, i_bit};
        w_diff    = w_partial - {1'b0, i_divisor};
        o_q_bit   = (w_partial >= {1'b0, i_divisor});
        o_rem     = o_q_bit ? w_diff[WIDTH-1:0] : w_partial[WIDTH-1:0];
    end

endmodule

`default_nettype wire

// File: rtl/mdu_hilo.sv
// ============================================================================
//  Module      : mdu_hilo
//  Description : Multiply/divide unit owning the HI/LO pair. Iterative
//                signed/unsigned multiply (or single-cycle when FAST_MUL=1)
//                and restoring divide on operand magnitudes with a final
//                sign-correction cycle; MTHI/MTLO write directly from IDLE.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int FAST_MUL = 0
) (
    input  wire logic    clk,
    input  wire logic    reset,
    mdu_hilo_if.slave    bus
);

    localparam int              CNT_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    mdu_state_e         r_state;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_a_raw;
    logic [WIDTH-1:0]   r_b_raw;
    logic [WIDTH-1:0]   r_a_mag;
    logic [WIDTH-1:0]   r_b_mag;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic               r_dz;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;
    logic               r_dbz;

    logic               w_is_mul;
    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [2*WIDTH-1:0] w_div_next;
    logic [WIDTH-1:0]   w_div_rem;
    logic               w_div_q;
    logic [2*WIDTH-1:0] w_fast_prod;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    // Operand conditioning from the values captured at the accepting edge.
    always_comb begin
        w_is_mul = (r_op == MDU_MULT) || (r_op == MDU_MULTU);
        w_signed = (r_op == MDU_MULT) || (r_op == MDU_DIV);
        w_a_neg  = w_signed & r_a_raw[WIDTH-1];
        w_b_neg  = w_signed & r_b_raw[WIDTH-1];
        w_a_mag  = w_a_neg ? -r_a_raw : r_a_raw;
        w_b_mag  = w_b_neg ? -r_b_raw : r_b_raw;
    end

    // Shift-add step: the multiplier sits in the low half of the
    // accumulator and is consumed LSB first while the product grows in.
    always_comb begin
        w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                     (r_acc[0] ? {1'b0, r_a_mag} : {(WIDTH+1){1'b0}});
        w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};
    end

    // Division keeps remainder in the high half and the dividend/quotient
    // shift register in the low half of the same accumulator.
    mdu_div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .i_rem     (r_acc[2*WIDTH-1:WIDTH]),
        .i_bit     (r_acc[WIDTH-1]),
        .i_divisor (r_b_mag),
        .o_rem     (w_div_rem),
        .o_q_bit   (w_div_q)
    );

    assign w_div_next = {w_div_rem, r_acc[WIDTH-2:0], w_div_q};

    generate
        if (FAST_MUL != 0) begin : g_fast_mul
            assign w_fast_prod = {{WIDTH{1'b0}}, w_a_mag} * {{WIDTH{1'b0}}, w_b_mag};
        end else begin : g_iter_mul
            assign w_fast_prod = '0;
        end
    endgenerate

    // Sign correction applied in FINISH.
    always_comb begin
        w_prod = r_neg_res ? -r_acc : r_acc;
        w_quo  = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        w_rem  = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    end

    // Sequencer, operand capture, iteration and HI/LO update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_op      <= '0;
            r_a_raw   <= '0;
            r_b_raw   <= '0;
            r_a_mag   <= '0;
            r_b_mag   <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_dz      <= 1'b0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dbz     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            if (bus.cancel && (r_state != S_IDLE)) begin
                // Exception flush: abandon the operation, HI/LO untouched.
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.start && !bus.cancel) begin
                            if (mdu_is_muldiv(bus.op)) begin
                                r_op    <= bus.op;
                                r_a_raw <= bus.rs;
                                r_b_raw <= bus.rt;
                                r_state <= S_PREP;
                                r_busy  <= 1'b1;
                            end else if (bus.op == MDU_MTHI) begin
                                r_hi <= bus.rs;
                            end else if (bus.op == MDU_MTLO) begin
                                r_lo <= bus.rs;
                            end
                        end
                    end
                    S_PREP: begin
                        r_a_mag   <= w_a_mag;
                        r_b_mag   <= w_b_mag;
                        r_neg_res <= w_a_neg ^ w_b_neg;
                        r_neg_rem <= w_a_neg;
                        r_dz      <= !w_is_mul && (r_b_raw == '0);
                        r_cnt     <= c_cnt_init;
                        if (w_is_mul) begin
                            if (FAST_MUL != 0) begin
                                r_acc   <= w_fast_prod;
                                r_state <= S_FINISH;
                            end else begin
                                r_acc   <= {{WIDTH{1'b0}}, w_b_mag};
                                r_state <= S_MUL_RUN;
                            end
                        end else begin
                            r_acc   <= {{WIDTH{1'b0}}, w_a_mag};
                            r_state <= S_DIV_RUN;
                        end
                    end
                    S_MUL_RUN, S_DIV_RUN: begin
                        r_acc <= (r_state == S_MUL_RUN) ? w_mul_next : w_div_next;
                        if (r_cnt == '0) begin
                            r_state <= S_FINISH;
                        end else begin
                            r_cnt <= r_cnt - c_cnt_one;
                        end
                    end
                    S_FINISH: begin
                        if (w_is_mul) begin
                            r_hi <= w_prod[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod[WIDTH-1:0];
                        end else if (r_dz) begin
                            // Divide by zero: all-ones quotient, dividend echoed in HI.
                            r_hi  <= r_a_raw;
                            r_lo  <= '1;
                            r_dbz <= 1'b1;
                        end else begin
                            r_hi <= w_rem;
                            r_lo <= w_quo;
                        end
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dbz;
    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mdu_hilo.sv
// ============================================================================
//  Module      : tb_mdu_hilo
//  Description : Self-checking bench for mdu_hilo: directed corner cases plus
//                randomized mul/div against a plain-arithmetic HI/LO model,
//                for both the iterative and the single-cycle multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdu_hilo;
    import mdu_pkg::*;

    logic clk;
    logic reset;

    mdu_hilo_if #(.WIDTH(32)) bus   ();
    mdu_hilo_if #(.WIDTH(32)) bus_f ();

    mdu_hilo #(.WIDTH(32), .FAST_MUL(0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    mdu_hilo #(.WIDTH(32), .FAST_MUL(1)) dut_f (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_f)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Architectural result of one mul/div, straight from integer arithmetic.
    function automatic void ref_model(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b, output logic [31:0] h,
                                      output logic [31:0] l, output logic dz);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 1'b0;
        h  = '0;
        l  = '0;
        case (op)
            MDU_MULT: begin
                p = sa * sb;
                h = p[63:32];
                l = p[31:0];
            end
            MDU_MULTU: begin
                p = {32'h0, a} * {32'h0, b};
                h = p[63:32];
                l = p[31:0];
            end
            default: begin
                if (b == 32'h0) begin
                    dz = 1'b1;
                    h  = a;
                    l  = 32'hFFFF_FFFF;
                end else if (op == MDU_DIV) begin
                    q = sa / sb;
                    r = sa % sb;
                    h = r[31:0];
                    l = q[31:0];
                end else begin
                    h = a % b;
                    l = a / b;
                end
            end
        endcase
    endfunction

    // Issue one mul/div and check latency, result and pulses. With poke set,
    // an MTHI is attempted mid-flight and must be ignored.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit poke);
        logic [31:0] e_hi, e_lo;
        logic        e_dz;
        int          lat;
        ref_model(op, a, b, e_hi, e_lo, e_dz);
        bus.start = 1'b1;
        bus.op    = op;
        bus.rs    = a;
        bus.rt    = b;
        tick();
        bus.start = 1'b0;
        bus.rs    = $urandom;
        bus.rt    = $urandom;
        chk("busy_rise", bus.busy, 1);
        lat = 0;
        while (!bus.done && lat < 100) begin
            if (poke && lat == 5) begin
                bus.start = 1'b1;
                bus.op    = MDU_MTHI;
            end
            tick();
            lat++;
            bus.start = 1'b0;
            if (lat == 8) begin
                chk("hold_hi", bus.hi, m_hi);
                chk("hold_lo", bus.lo, m_lo);
            end
        end
        chk("latency", lat, 34);
        chk("res_hi", bus.hi, e_hi);
        chk("res_lo", bus.lo, e_lo);
        chk("dbz", bus.div_by_zero, e_dz);
        chk("busy_done", bus.busy, 0);
        m_hi = e_hi;
        m_lo = e_lo;
        tick();
        chk("done_pulse", bus.done, 0);
    endtask

    // Launch an op, cancel it 'at' cycles after acceptance, expect no effect.
    task automatic run_cancel(input logic [2:0] op, input logic [31:0] a,
                              input logic [31:0] b, input int at);
        bit seen;
        bus.start = 1'b1;
        bus.op    = op;
        bus.rs    = a;
        bus.rt    = b;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < at; i++) tick();
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        chk("cancel_busy", bus.busy, 0);
        seen = bus.done;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done) seen = 1'b1;
        end
        chk("cancel_nodone", seen, 0);
        chk("cancel_hi", bus.hi, m_hi);
        chk("cancel_lo", bus.lo, m_lo);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b, e_hi, e_lo;
        logic        e_dz;
        int          lat;

        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.op      = '0;
        bus.rs      = '0;
        bus.rt      = '0;
        bus.cancel  = 1'b0;
        bus_f.start = 1'b0;
        bus_f.op    = '0;
        bus_f.rs    = '0;
        bus_f.rt    = '0;
        bus_f.cancel = 1'b0;
        m_hi = '0;
        m_lo = '0;

        #12;
        chk("rst_hi", bus.hi, 0);
        chk("rst_lo", bus.lo, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_dbz", bus.div_by_zero, 0);
        tick();
        reset = 1'b0;

        // MTHI then MTLO back to back.
        bus.start = 1'b1;
        bus.op    = MDU_MTHI;
        bus.rs    = 32'h1234;
        tick();
        chk("mthi_busy", bus.busy, 0);
        chk("mthi_done", bus.done, 0);
        chk("mthi_hi", bus.hi, 32'h1234);
        bus.op = MDU_MTLO;
        bus.rs = 32'h5678;
        tick();
        bus.start = 1'b0;
        chk("mtlo_busy", bus.busy, 0);
        chk("mtlo_done", bus.done, 0);
        chk("mtlo_hi", bus.hi, 32'h1234);
        chk("mtlo_lo", bus.lo, 32'h5678);
        m_hi = 32'h1234;
        m_lo = 32'h5678;

        // Reserved codes do nothing.
        for (int k = 6; k < 8; k++) begin
            bus.start = 1'b1;
            bus.op    = 3'(k);
            bus.rs    = 32'hDEAD_BEEF;
            tick();
            bus.start = 1'b0;
            chk("rsv_busy", bus.busy, 0);
            tick();
            chk("rsv_done", bus.done, 0);
            chk("rsv_hi", bus.hi, m_hi);
            chk("rsv_lo", bus.lo, m_lo);
        end

        // Start with cancel while idle: start dropped.
        bus.start  = 1'b1;
        bus.cancel = 1'b1;
        bus.op     = MDU_MTHI;
        bus.rs     = 32'hCAFE_0001;
        tick();
        chk("sc_mthi_hi", bus.hi, m_hi);
        bus.op = MDU_DIV;
        tick();
        chk("sc_div_busy", bus.busy, 0);
        bus.start  = 1'b0;
        bus.cancel = 1'b0;

        // Directed corner cases.
        run_op(MDU_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 1'b1);
        run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(MDU_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
        run_op(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run_op(MDU_DIVU,  32'd100,       32'h0,         1'b0);
        run_op(MDU_DIV,   32'hFFFF_FF9C, 32'h0,         1'b0);
        run_op(MDU_MULT,  32'h8000_0000, 32'h8000_0000, 1'b0);

        // Cancel in PREP, mid-run and in FINISH.
        run_cancel(MDU_DIV,  32'd1000,      32'd7,  10);
        run_cancel(MDU_MULT, 32'h1234_5678, 32'd9,  0);
        run_cancel(MDU_DIVU, 32'hFFFF_0000, 32'd3,  33);

        // Asynchronous reset in the middle of an operation.
        bus.start = 1'b1;
        bus.op    = MDU_DIV;
        bus.rs    = 32'd77;
        bus.rt    = 32'd5;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        #2 reset = 1'b1;
        #1;
        chk("arst_hi", bus.hi, 0);
        chk("arst_lo", bus.lo, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_done", bus.done, 0);
        tick();
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        tick();

        // Single-cycle multiplier instance.
        for (int i = 0; i < 8; i++) begin
            op = 3'($urandom_range(0, 1));
            a  = (i == 0) ? 32'h8000_0000 : $urandom;
            b  = (i == 0) ? 32'hFFFF_FFFF : $urandom;
            ref_model(op, a, b, e_hi, e_lo, e_dz);
            bus_f.start = 1'b1;
            bus_f.op    = op;
            bus_f.rs    = a;
            bus_f.rt    = b;
            tick();
            bus_f.start = 1'b0;
            lat = 0;
            while (!bus_f.done && lat < 20) begin
                tick();
                lat++;
            end
            chk("fast_lat", lat, 2);
            chk("fast_hi", bus_f.hi, e_hi);
            chk("fast_lo", bus_f.lo, e_lo);
            tick();
        end

        // Randomized mul/div with occasional corner operands.
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 5));
                3: a = 32'($urandom_range(0, 9));
                default: ;
            endcase
            run_op(op, a, b, (i % 5) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
